// File: rtl/ps2_port.sv
// Receive-only PS/2 host port: filters the lines, deframes device frames
// into a byte FIFO read over the NORA slave bus; inhibits clock when full.
module ps2_port #(
  parameter int DEPTH       = 8,
  parameter int FILTER      = 8,
  parameter int TIMEOUT_CYC = 7200
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clkdr_o,
  output logic       ps2_datadr_o,
  input  logic [1:0] slv_addr_i,
  input  logic [7:0] slv_datawr_i,
  input  logic       slv_datawr_valid,
  output logic [7:0] slv_datard_o,
  input  logic       slv_req_i,
  input  logic       slv_rwn_i,
  output logic       irq_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t state_q, state_d;

  logic [1:0]         sync0_q, sync1_q;
  logic [1:0]         filt_q;
  logic [1:0][FW-1:0] fcnt_q;
  logic               fall_q;

  logic [3:0]         bitcnt_q;
  logic [9:0]         frame_q;
  logic [TW-1:0]      tcnt_q;

  logic               push, set_ferr, set_perr, set_ovf;
  logic               perr_q, ferr_q, ovf_q;

  logic [7:0]         mem [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [3:0]         count_q;
  logic               full, avail;

  logic               wr_en, flush, rd_flag_q, pop;
  logic               unused_wr;

  assign full  = count_q == 4'(DEPTH);
  assign avail = count_q != 4'd0;

  assign ps2_clkdr_o  = full;
  assign ps2_datadr_o = 1'b0;
  assign irq_o        = avail;

  assign wr_en = slv_req_i & ~slv_rwn_i & slv_datawr_valid
               & (slv_addr_i == 2'd0);
  assign flush = wr_en & slv_datawr_i[7];
  assign pop   = rd_flag_q & ~slv_req_i & avail;

  assign unused_wr = ^{slv_datawr_i[6:5], slv_datawr_i[1:0]};

  // bit 0 = clock line, bit 1 = data line
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      sync0_q <= 2'b11;
      sync1_q <= 2'b11;
      filt_q  <= 2'b11;
      fcnt_q  <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync0_q <= {ps2_data_i, ps2_clk_i};
      sync1_q <= sync0_q;
      fall_q  <= filt_q[0] & ~sync1_q[0]
               & (fcnt_q[0] == FW'(FILTER - 1));
      for (int i = 0; i < 2; i++) begin
        if (sync1_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FW'(FILTER - 1)) begin
          filt_q[i] <= sync1_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    set_ferr = 1'b0;
    set_perr = 1'b0;
    set_ovf  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall_q) begin
          if (filt_q[1]) set_ferr = 1'b1;
          else           state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (fall_q && bitcnt_q == 4'd9) begin
          state_d = CHECK;
        end else if (!fall_q && tcnt_q == TW'(TIMEOUT_CYC)) begin
          set_ferr = 1'b1;
          state_d  = IDLE;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!frame_q[9])             set_ferr = 1'b1;
        else if (^frame_q[8:0] == 0) set_perr = 1'b1;
        else if (full)               set_ovf  = 1'b1;
        else                         push     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      bitcnt_q <= '0;
      frame_q  <= '0;
      tcnt_q   <= '0;
    end else begin
      if (state_q != SHIFT || fall_q) tcnt_q <= '0;
      else                            tcnt_q <= tcnt_q + 1'b1;
      if (state_q == IDLE) begin
        bitcnt_q <= '0;
      end else if (state_q == SHIFT && fall_q) begin
        bitcnt_q <= bitcnt_q + 1'b1;
        frame_q  <= {filt_q[1], frame_q[9:1]};
      end
    end
  end

  // flush beats a same-cycle push or pop
  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_q] <= frame_q[7:0];
        wr_ptr_q      <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + 4'(push) - 4'(pop);
    end
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
      rd_flag_q <= 1'b0;
    end else begin
      perr_q    <= (perr_q & ~(wr_en & slv_datawr_i[2])) | set_perr;
      ferr_q    <= (ferr_q & ~(wr_en & slv_datawr_i[3])) | set_ferr;
      ovf_q     <= (ovf_q  & ~(wr_en & slv_datawr_i[4])) | set_ovf;
      rd_flag_q <= slv_req_i & slv_rwn_i & (slv_addr_i == 2'd1);
    end
  end

  always_comb begin
    slv_datard_o = '0;
    unique case (slv_addr_i)
      2'd0: slv_datard_o = {3'b0, ovf_q, ferr_q, perr_q, full, avail};
      2'd1: slv_datard_o = avail ? mem[rd_ptr_q] : 8'h00;
      2'd2: slv_datard_o = {4'b0, count_q};
      default: slv_datard_o = '0;
    endcase
  end

endmodule

// File: tb/tb_ps2_port.sv
// Bench for ps2_port: random frames against a queue model, with a
// bus monitor checking every DATA read against the expected byte.
`timescale 1ns/1ps
module tb_ps2_port;

  localparam int DEPTH = 8;
  localparam int FILT  = 4;
  localparam int TOUT  = 100;

  logic       clk6x = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       clkdr, datadr, irq;
  logic [1:0] addr = 2'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       valid = 1'b0;
  logic       req = 1'b0;
  logic       rwn = 1'b1;

  always #5 clk6x = ~clk6x;

  ps2_port #(
    .DEPTH(DEPTH),
    .FILTER(FILT),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk6x(clk6x),
    .resetn(resetn),
    .ps2_clk_i(ps2_clk),
    .ps2_data_i(ps2_data),
    .ps2_clkdr_o(clkdr),
    .ps2_datadr_o(datadr),
    .slv_addr_i(addr),
    .slv_datawr_i(wdata),
    .slv_datawr_valid(valid),
    .slv_datard_o(rdata),
    .slv_req_i(req),
    .slv_rwn_i(rwn),
    .irq_o(irq)
  );

  int ntests = 0;
  int nfail  = 0;
  logic [7:0] exp_q[$];
  bit m_perr, m_ferr, m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk6x);
    #1;
  endtask

  // bus monitor: every DATA read access is scored at its end
  bit         in_rd = 1'b0;
  logic [7:0] mon_first, mon_last, mon_exp;
  always @(negedge clk6x) begin
    if (resetn && req && rwn && addr == 2'd1) begin
      if (!in_rd) mon_first = rdata;
      mon_last = rdata;
      in_rd = 1'b1;
    end else if (in_rd && !req) begin
      in_rd = 1'b0;
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      chk("data_first", int'(mon_first), int'(mon_exp));
      chk("data_last", int'(mon_last), int'(mon_exp));
    end
  end

  task automatic rd_reg(input logic [1:0] a, output logic [7:0] v);
    addr = a; rwn = 1'b1; req = 1'b1;
    tick(2);
    @(negedge clk6x);
    v = rdata;
    @(posedge clk6x);
    #1;
    req = 1'b0;
    tick(1);
  endtask

  task automatic rd_data();
    addr = 2'd1; rwn = 1'b1; req = 1'b1;
    tick(3);
    req = 1'b0;
    tick(2);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    addr = a; rwn = 1'b0; wdata = d; req = 1'b1;
    tick(1);
    valid = 1'b1;
    tick(1);
    valid = 1'b0; req = 1'b0; rwn = 1'b1;
    tick(1);
    if (a == 2'd0) begin
      if (d[2]) m_perr = 1'b0;
      if (d[3]) m_ferr = 1'b0;
      if (d[4]) m_ovf  = 1'b0;
      if (d[7]) exp_q.delete();
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] v;
    int n;
    n = exp_q.size();
    rd_reg(2'd0, v);
    chk({tag, "_status"}, int'(v),
        int'({3'b0, m_ovf, m_ferr, m_perr, n == DEPTH, n != 0}));
    rd_reg(2'd2, v);
    chk({tag, "_count"}, int'(v), n);
    @(negedge clk6x);
    chk({tag, "_irq"}, int'(irq), int'(n != 0));
    chk({tag, "_inhibit"}, int'(clkdr), int'(n == DEPTH));
    tick(1);
  endtask

  // mode 1: DATA read ends on the push cycle; mode 2: flush on it
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input int nbits,
                            input int mode, input bit glitch);
    logic [10:0] fr;
    int h;
    fr = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
    h = int'($urandom_range(24, 12));
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      tick(h);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        tick(FILT);
        addr = 2'd1; rwn = 1'b1; req = 1'b1;
        tick(3);
        req = 1'b0;
        tick(h - FILT - 3);
      end else if (i == 10 && mode == 2) begin
        tick(FILT + 3);
        addr = 2'd0; rwn = 1'b0; wdata = 8'h80;
        req = 1'b1; valid = 1'b1;
        tick(1);
        valid = 1'b0; req = 1'b0; rwn = 1'b1;
        tick(h - FILT - 4);
      end else begin
        tick(h);
      end
      ps2_clk = 1'b1;
      if (glitch && i == 3) begin
        tick(10);
        ps2_clk = 1'b0;
        tick(1);
        ps2_clk = 1'b1;
        tick(4);
        ps2_clk = 1'b0;
        tick(FILT - 1);
        ps2_clk = 1'b1;
      end
    end
    ps2_data = 1'b1;
    tick(40);
    if (nbits == 11) begin
      if (mode == 2)                  exp_q.delete();
      else if (bad_stop)              m_ferr = 1'b1;
      else if (bad_par)               m_perr = 1'b1;
      else if (exp_q.size() == DEPTH) m_ovf = 1'b1;
      else                            exp_q.push_back(b);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] v;
    int r;
    tick(3);
    @(negedge clk6x);
    chk("rst_irq", int'(irq), 0);
    chk("rst_inhibit", int'(clkdr), 0);
    chk("rst_datadr", int'(datadr), 0);
    chk("rst_rdata", int'(rdata), 0);
    resetn = 1'b1;
    tick(5);
    check_state("reset");

    send_frame(8'h1C, 0, 0, 11, 0, 0);
    send_frame(8'hF0, 0, 0, 11, 0, 0);
    send_frame(8'h1C, 0, 0, 11, 0, 0);
    check_state("three");
    rd_data();
    rd_data();
    rd_data();
    check_state("drained");
    rd_data();

    send_frame(8'h5A, 1, 0, 11, 0, 0);
    check_state("perr");
    send_frame(8'h3C, 0, 1, 11, 0, 0);
    check_state("ferr");
    wr_reg(2'd0, 8'h0C);
    check_state("w1c");

    wr_reg(2'd1, 8'hFF);
    rd_reg(2'd3, v);
    chk("addr3", int'(v), 0);
    check_state("ignored_wr");

    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 0, 0, 11, 0, 0);
    end
    check_state("full");
    send_frame(8'h99, 0, 0, 11, 0, 0);
    check_state("ovf");
    rd_data();
    check_state("pop_full");

    wr_reg(2'd0, 8'h9C);
    send_frame(8'h33, 0, 0, 5, 0, 0);
    check_state("pre_timeout");
    tick(TOUT);
    m_ferr = 1'b1;
    check_state("timeout");
    wr_reg(2'd0, 8'h08);
    send_frame(8'h29, 0, 0, 11, 0, 0);
    check_state("after_timeout");
    rd_data();

    send_frame(8'hA5, 0, 0, 11, 0, 1);
    check_state("glitch");
    rd_data();

    send_frame(8'h11, 0, 0, 11, 0, 0);
    send_frame(8'h22, 0, 0, 11, 0, 0);
    send_frame(8'h44, 0, 0, 11, 0, 0);
    send_frame(8'h88, 0, 0, 11, 1, 0);
    check_state("push_pop");
    send_frame(8'h66, 0, 0, 11, 2, 0);
    check_state("flush_push");

    send_frame(8'h12, 0, 0, 11, 0, 0);
    send_frame(8'h34, 0, 0, 11, 0, 0);
    send_frame(8'h56, 0, 0, 5, 0, 0);
    resetn = 1'b0;
    addr = 2'd2;
    tick(2);
    @(negedge clk6x);
    chk("midrst_count", int'(rdata), 0);
    chk("midrst_irq", int'(irq), 0);
    exp_q.delete();
    m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(3);
    check_state("post_reset");
    send_frame(8'h77, 0, 0, 11, 0, 0);
    check_state("post_reset_frame");
    rd_data();

    for (int k = 0; k < 14; k++) begin
      r = int'($urandom_range(9, 0));
      b = 8'($urandom);
      send_frame(b, r == 0, r == 1, 11, 0, 0);
      if ($urandom_range(2, 0) == 0) rd_data();
      check_state("rand");
    end
    while (exp_q.size() != 0) rd_data();
    check_state("final");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
